perm_round_ctrl: RTL and testbench

PERM_ROUND_CTRL -- requirements
Module: perm_round_ctrl

---
 rtl/perm_round_ctrl.sv | 108 ++++++++++
 tb/tb_perm_round_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/perm_round_ctrl.sv
// perm_round_ctrl: round sequencer (IDLE/RUN/DONE) driving a p12/p6 permutation core.
// Optional macro PERM_P8_EN adds the p8 mode (rounds 4..11) on mode_i=2'b10.
module perm_round_ctrl (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [1:0] mode_i,
    input  logic       abort_i,
    output logic [3:0] round_o,
    output logic       select_o,
    output logic       enable_o,
    output logic       busy_o,
    output logic       done_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'd11;

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       select_q, select_d;
    logic       enable_q, enable_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Every mode ends on round 11, so only the starting round depends on the mode.
    function automatic logic [3:0] first_round(input logic [1:0] mode);
        logic [3:0] r;
        r = 4'd0;
        case (mode)
            2'b01:   r = 4'd6;
`ifdef PERM_P8_EN
            2'b10:   r = 4'd4;
`endif
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            round_q  <= 4'd0;
            select_q <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            select_q <= select_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        select_d = 1'b0;
        enable_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = RUN;
                    round_d  = first_round(mode_i);
                    enable_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            RUN: begin
                // Abort outranks the final-round transition, so an aborted run never pulses done.
                if (abort_i) begin
                    state_d = IDLE;
                end else if (round_q == LAST_ROUND) begin
                    state_d = DONE;
                    busy_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    round_d  = round_q + 4'd1;
                    select_d = 1'b1;
                    enable_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign round_o  = round_q;
    assign select_o = select_q;
    assign enable_o = enable_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_perm_round_ctrl.sv
// Testbench for perm_round_ctrl: directed and randomized runs checked against a
// transaction-level model (a run of mode m visits rounds first(m)..11, then one DONE cycle).
module tb_perm_round_ctrl;
    logic       clock_i;
    logic       reset_i;
    logic       start_i;
    logic [1:0] mode_i;
    logic       abort_i;
    logic [3:0] round_o;
    logic       select_o;
    logic       enable_o;
    logic       busy_o;
    logic       done_o;

    int total = 0;
    int bad   = 0;
    int last_r = 0;

`ifdef PERM_P8_EN
    localparam bit P8 = 1'b1;
`else
    localparam bit P8 = 1'b0;
`endif

    perm_round_ctrl dut (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .start_i  (start_i),
        .mode_i   (mode_i),
        .abort_i  (abort_i),
        .round_o  (round_o),
        .select_o (select_o),
        .enable_o (enable_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    function automatic int exp_first(input logic [1:0] mode);
        if (mode == 2'b01) return 6;
        if (mode == 2'b10 && P8) return 4;
        return 0;
    endfunction

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] r, input logic s, input logic e,
                       input logic b, input logic d, input bit chk_s);
        total++;
        assert (round_o === r) else begin
            bad++; $error("FAIL %s round_o got=%0d want=%0d", tag, round_o, r);
        end
        if (chk_s) begin
            total++;
            assert (select_o === s) else begin
                bad++; $error("FAIL %s select_o got=%b want=%b", tag, select_o, s);
            end
        end
        total++;
        assert (enable_o === e) else begin
            bad++; $error("FAIL %s enable_o got=%b want=%b", tag, enable_o, e);
        end
        total++;
        assert (busy_o === b) else begin
            bad++; $error("FAIL %s busy_o got=%b want=%b", tag, busy_o, b);
        end
        total++;
        assert (done_o === d) else begin
            bad++; $error("FAIL %s done_o got=%b want=%b", tag, done_o, d);
        end
    endtask

    // Entered and left during an IDLE cycle, 1 time unit after a rising edge.
    task automatic run_check(input logic [1:0] mode, input int abort_k, input bit hold,
                             input bit noise, input string tag);
        int first;
        int n;
        first   = exp_first(mode);
        n       = 12 - first;
        start_i = 1'b1;
        mode_i  = mode;
        abort_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        abort_i = 1'b0;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s run k=%0d", tag, k), 4'(first + k), (k != 0), 1'b1, 1'b1, 1'b0, 1'b1);
            start_i = hold ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            if (noise) mode_i = (k == 0) ? (mode ^ 2'b01) : 2'($urandom_range(0, 3));
            if (k == abort_k) begin
                abort_i = 1'b1;
                step();
                abort_i = 1'b0;
                start_i = hold;
                chk($sformatf("%s abort k=%0d", tag, k), 4'(first + k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                last_r = first + k;
                return;
            end
            step();
        end
        chk({tag, " done"}, 4'd11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk({tag, " idle"}, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        last_r  = 11;
        start_i = hold;
    endtask

    initial begin
        reset_i = 1'b0;
        start_i = 1'b0;
        mode_i  = 2'b00;
        abort_i = 1'b0;
        #2;
        chk("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clock_i);
        reset_i = 1'b1;

        run_check(2'b00, -1, 1'b0, 1'b0, "p12");
        run_check(2'b01, -1, 1'b0, 1'b0, "p6");
        run_check(2'b10, -1, 1'b0, 1'b0, "mode10");
        run_check(2'b11, -1, 1'b0, 1'b0, "mode11");

        // abort in IDLE has no effect
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("idle abort", 4'(last_r), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        run_check(2'b00, 5, 1'b0, 1'b0, "abort r5");
        run_check(2'b00, -1, 1'b0, 1'b0, "after abort");
        run_check(2'b01, 5, 1'b0, 1'b0, "abort r11");
        run_check(2'b00, -1, 1'b0, 1'b1, "mode change");

        run_check(2'b00, -1, 1'b1, 1'b0, "b2b a");
        run_check(2'b00, -1, 1'b1, 1'b0, "b2b b");
        start_i = 1'b0;

        // asynchronous reset at round 7 of a p12 run
        start_i = 1'b1;
        mode_i  = 2'b00;
        step();
        start_i = 1'b0;
        for (int k = 0; k < 7; k++) step();
        chk("pre-reset r7", 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        #2;
        reset_i = 1'b0;
        #1;
        chk("async reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk("held reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset_i = 1'b1;
        last_r  = 0;
        run_check(2'b10, -1, 1'b0, 1'b0, "post-reset mode10");

        for (int i = 0; i < 24; i++) begin
            logic [1:0] m;
            int ak;
            m  = 2'($urandom_range(0, 3));
            ak = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11)) : -1;
            run_check(m, ak, 1'b0, 1'b1, $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1) begin
                start_i = 1'b0;
                step();
                chk($sformatf("rand%0d gap", i), 4'(last_r), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
